// File: rtl/delta_out_seq.sv
// delta_out_seq: sequential output-layer delta (a-t)*a*(1-a) and cost (a-t) over NEURON neurons, one shared multiplier.
// Optional feature macro DELTA_OUT_SEQ_MSE_EN adds an SQR state per neuron and the o_mse output.
module delta_out_seq #(
    parameter int WIDTH  = 32,
    parameter int FRAC   = 24,
    parameter int NEURON = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic [NEURON*WIDTH-1:0] i_a,
    input  logic [NEURON*WIDTH-1:0] i_t,
    output logic [NEURON*WIDTH-1:0] o_delta,
    output logic [NEURON*WIDTH-1:0] o_cost,
    output logic                    o_busy,
    output logic                    o_valid
`ifdef DELTA_OUT_SEQ_MSE_EN
    ,
    output logic [WIDTH-1:0]        o_mse
`endif
);
    localparam int IDX_W = (NEURON > 1) ? $clog2(NEURON) : 1;
    localparam int VW    = NEURON * WIDTH;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << FRAC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DERIV,
        S_DELTA,
`ifdef DELTA_OUT_SEQ_MSE_EN
        S_SQR,
`endif
        S_DONE
    } state_e;

    // Signed fixed-point product: floor shift by FRAC, low WIDTH bits kept, no saturation.
    function automatic logic [WIDTH-1:0] mult(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic signed [2*WIDTH-1:0] p;
        p = $signed({{WIDTH{x[WIDTH-1]}}, x}) * $signed({{WIDTH{y[WIDTH-1]}}, y});
        p = p >>> FRAC;
        return p[WIDTH-1:0];
    endfunction

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [VW-1:0]    a_q, a_d, t_q, t_d;
    logic [WIDTH-1:0] diff_q, diff_d, s_q, s_d;
    logic [VW-1:0]    sh_delta_q, sh_delta_d, sh_cost_q, sh_cost_d;
    logic [VW-1:0]    delta_q, delta_d, cost_q, cost_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] cur_a, cur_t;
    logic             last;
`ifdef DELTA_OUT_SEQ_MSE_EN
    logic [WIDTH-1:0]        acc_q, acc_d, mse_q, mse_d;
    logic [WIDTH-1:0]        sq;
    logic signed [WIDTH-1:0] half_sq;
`endif

    // NOTE: the shadow and output banks are only a few words, so they are reset like any other
    // register; reset must discard a partial batch and zero the published results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            a_q        <= '0;
            t_q        <= '0;
            diff_q     <= '0;
            s_q        <= '0;
            sh_delta_q <= '0;
            sh_cost_q  <= '0;
            delta_q    <= '0;
            cost_q     <= '0;
            valid_q    <= 1'b0;
`ifdef DELTA_OUT_SEQ_MSE_EN
            acc_q      <= '0;
            mse_q      <= '0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q    <= state_d;
            idx_q      <= idx_d;
            a_q        <= a_d;
            t_q        <= t_d;
            diff_q     <= diff_d;
            s_q        <= s_d;
            sh_delta_q <= sh_delta_d;
            sh_cost_q  <= sh_cost_d;
            delta_q    <= delta_d;
            cost_q     <= cost_d;
            valid_q    <= valid_d;
`ifdef DELTA_OUT_SEQ_MSE_EN
            acc_q      <= acc_d;
            mse_q      <= mse_d;
`endif
        end
    end

    assign last = (idx_q == IDX_W'(NEURON - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start) state_d = S_DERIV;
            S_DERIV: state_d = S_DELTA;
`ifdef DELTA_OUT_SEQ_MSE_EN
            S_DELTA: state_d = S_SQR;
            S_SQR:   state_d = last ? S_DONE : S_DERIV;
`else
            S_DELTA: state_d = last ? S_DONE : S_DERIV;
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cur_a      = a_q[int'(idx_q)*WIDTH +: WIDTH];
        cur_t      = t_q[int'(idx_q)*WIDTH +: WIDTH];
        idx_d      = idx_q;
        a_d        = a_q;
        t_d        = t_q;
        diff_d     = diff_q;
        s_d        = s_q;
        sh_delta_d = sh_delta_q;
        sh_cost_d  = sh_cost_q;
        delta_d    = delta_q;
        cost_d     = cost_q;
        valid_d    = 1'b0;
`ifdef DELTA_OUT_SEQ_MSE_EN
        acc_d      = acc_q;
        mse_d      = mse_q;
        sq         = mult(diff_q, diff_q);
        half_sq    = $signed(sq) >>> 1;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    a_d   = i_a;
                    t_d   = i_t;
                    idx_d = '0;
`ifdef DELTA_OUT_SEQ_MSE_EN
                    acc_d = '0;
`endif
                end
            end
            S_DERIV: begin
                diff_d = cur_a - cur_t;
                s_d    = mult(cur_a, ONE - cur_a);
            end
            S_DELTA: begin
                sh_delta_d[int'(idx_q)*WIDTH +: WIDTH] = mult(diff_q, s_q);
                sh_cost_d[int'(idx_q)*WIDTH +: WIDTH]  = diff_q;
`ifndef DELTA_OUT_SEQ_MSE_EN
                if (!last) idx_d = idx_q + IDX_W'(1);
`endif
            end
`ifdef DELTA_OUT_SEQ_MSE_EN
            S_SQR: begin
                acc_d = acc_q + half_sq;
                if (!last) idx_d = idx_q + IDX_W'(1);
            end
`endif
            S_DONE: begin
                delta_d = sh_delta_q;
                cost_d  = sh_cost_q;
                valid_d = 1'b1;
`ifdef DELTA_OUT_SEQ_MSE_EN
                mse_d   = acc_q;
`endif
            end
            default: ;
        endcase
    end

    always_comb begin
        o_busy  = (state_q != S_IDLE);
        o_valid = valid_q;
        o_delta = delta_q;
        o_cost  = cost_q;
`ifdef DELTA_OUT_SEQ_MSE_EN
        o_mse   = mse_q;
`endif
    end

endmodule

// File: tb/tb_delta_out_seq.sv
// Self-checking bench for delta_out_seq: NEURON=4 and NEURON=1 instances against a plain-arithmetic model.
module tb_delta_out_seq;
    localparam int W = 32;
    localparam int F = 24;
    localparam int N = 4;
`ifdef DELTA_OUT_SEQ_MSE_EN
    localparam int LAT4 = 3*N + 1;
    localparam int LAT1 = 4;
`else
    localparam int LAT4 = 2*N + 1;
    localparam int LAT1 = 3;
`endif

    logic clk = 1'b0;
    logic rst;
    logic start4, start1;
    logic [N*W-1:0] a4, t4, delta4, cost4;
    logic [W-1:0]   a1, t1, delta1, cost1;
    logic busy4, valid4, busy1, valid1;
`ifdef DELTA_OUT_SEQ_MSE_EN
    logic [W-1:0] mse4, mse1;
`endif

    int errors = 0;
    int checks = 0;
    logic [N*W-1:0] exp_d[2], exp_c[2], prev_d[2], prev_c[2];
    logic [W-1:0]   exp_m[2];

    always #5 clk = ~clk;

    delta_out_seq #(.WIDTH(W), .FRAC(F), .NEURON(N)) dut4 (
        .clk(clk), .rst(rst), .i_start(start4), .i_a(a4), .i_t(t4),
        .o_delta(delta4), .o_cost(cost4), .o_busy(busy4), .o_valid(valid4)
`ifdef DELTA_OUT_SEQ_MSE_EN
        , .o_mse(mse4)
`endif
    );

    delta_out_seq #(.WIDTH(W), .FRAC(F), .NEURON(1)) dut1 (
        .clk(clk), .rst(rst), .i_start(start1), .i_a(a1), .i_t(t1),
        .o_delta(delta1), .o_cost(cost1), .o_busy(busy1), .o_valid(valid1)
`ifdef DELTA_OUT_SEQ_MSE_EN
        , .o_mse(mse1)
`endif
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int mul(input int x, input int y);
        longint p;
        p = longint'(x) * longint'(y);
        return int'(p >>> F);
    endfunction

    // Reference: per neuron cost = a-t, delta = cost*a*(1-a), mse = sum of cost^2/2, all wrapping.
    task automatic model(input logic [N*W-1:0] a, input logic [N*W-1:0] t, input int cnt,
                         output logic [N*W-1:0] d, output logic [N*W-1:0] c, output logic [W-1:0] m);
        int ai, ti, diff, acc;
        d = '0;
        c = '0;
        acc = 0;
        for (int n = 0; n < cnt; n++) begin
            ai = int'(a[n*W +: W]);
            ti = int'(t[n*W +: W]);
            diff = ai - ti;
            d[n*W +: W] = mul(diff, mul(ai, (1 << F) - ai));
            c[n*W +: W] = diff;
            acc += mul(diff, diff) >>> 1;
        end
        m = acc;
    endtask

    function automatic logic get_valid(input int u);
        return (u == 0) ? valid4 : valid1;
    endfunction
    function automatic logic get_busy(input int u);
        return (u == 0) ? busy4 : busy1;
    endfunction
    function automatic logic [N*W-1:0] get_delta(input int u);
        return (u == 0) ? delta4 : (N*W)'(delta1);
    endfunction
    function automatic logic [N*W-1:0] get_cost(input int u);
        return (u == 0) ? cost4 : (N*W)'(cost1);
    endfunction
    function automatic int lat(input int u);
        return (u == 0) ? LAT4 : LAT1;
    endfunction

    task automatic set_start(input int u, input logic v);
        if (u == 0) start4 = v;
        else start1 = v;
    endtask

    // Pulse start for one edge with the given operands, then scramble the inputs.
    task automatic start_batch(input int u, input logic [N*W-1:0] a, input logic [N*W-1:0] t);
        prev_d[u] = exp_d[u];
        prev_c[u] = exp_c[u];
        model(a, t, (u == 0) ? N : 1, exp_d[u], exp_c[u], exp_m[u]);
        if (u == 0) begin a4 = a; t4 = t; end
        else begin a1 = a[W-1:0]; t1 = t[W-1:0]; end
        set_start(u, 1'b1);
        @(negedge clk);
        set_start(u, 1'b0);
        a4 = {$urandom, $urandom, $urandom, $urandom};
        t4 = {$urandom, $urandom, $urandom, $urandom};
        a1 = $urandom;
        t1 = $urandom;
        check("busy_after_start", get_busy(u), 1'b1);
    endtask

    task automatic wait_valid(input int u, input string tag, input bit mid_start, output time tv);
        int cyc = 0;
        while (!get_valid(u) && cyc < 200) begin
            set_start(u, (mid_start && cyc == 4) ? 1'b1 : 1'b0);
            if (cyc == lat(u) - 1) begin
                check({tag, "_hold_delta"}, get_delta(u), prev_d[u]);
                check({tag, "_hold_cost"}, get_cost(u), prev_c[u]);
            end
            @(negedge clk);
            cyc++;
        end
        set_start(u, 1'b0);
        tv = $time;
        check({tag, "_latency"}, cyc, lat(u));
        check({tag, "_delta"}, get_delta(u), exp_d[u]);
        check({tag, "_cost"}, get_cost(u), exp_c[u]);
        check({tag, "_busy_low"}, get_busy(u), 1'b0);
`ifdef DELTA_OUT_SEQ_MSE_EN
        check({tag, "_mse"}, (u == 0) ? mse4 : mse1, exp_m[u]);
`endif
    endtask

    task automatic after_pulse(input int u, input string tag);
        @(negedge clk);
        check({tag, "_single_pulse"}, get_valid(u), 1'b0);
        check({tag, "_idle"}, get_busy(u), 1'b0);
    endtask

    function automatic logic [N*W-1:0] rand_vec(input bit act);
        logic [N*W-1:0] v;
        for (int n = 0; n < N; n++)
            v[n*W +: W] = act ? 32'($urandom_range(0, 32'h0100_0000)) : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 32'h0100_0000)));
        return v;
    endfunction

    initial begin
        logic [N*W-1:0] da, dt, ra, rt;
        time tv1, tv2;
        rst = 1'b1;
        start4 = 1'b0;
        start1 = 1'b0;
        a4 = '0; t4 = '0; a1 = '0; t1 = '0;
        for (int u = 0; u < 2; u++) begin
            exp_d[u] = '0; exp_c[u] = '0; exp_m[u] = '0;
        end
        #12;
        check("rst_delta", delta4, '0);
        check("rst_cost", cost4, '0);
        check("rst_busy", busy4, 1'b0);
        check("rst_valid", valid4, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        da = {32'h0100_0000, 32'h0040_0000, 32'h00C0_0000, 32'h0080_0000};
        dt = {32'h0000_0000, 32'h0040_0000, 32'h0000_0000, 32'h0100_0000};
        start_batch(0, da, dt);
        wait_valid(0, "dir", 1'b0, tv1);
        check("dir_delta_const", delta4, 128'h00000000_00000000_00240000_FFE00000);
        check("dir_cost_const", cost4, 128'h01000000_00000000_00C00000_FF800000);
`ifdef DELTA_OUT_SEQ_MSE_EN
        check("dir_mse_const", mse4, 32'h00E8_0000);
`endif
        after_pulse(0, "dir");

        start_batch(0, da, dt);
        wait_valid(0, "midstart", 1'b1, tv1);
        after_pulse(0, "midstart");

        start_batch(0, rand_vec(1'b1), rand_vec(1'b0));
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_delta", delta4, '0);
        check("arst_cost", cost4, '0);
        check("arst_busy", busy4, 1'b0);
        check("arst_valid", valid4, 1'b0);
        for (int u = 0; u < 2; u++) begin
            exp_d[u] = '0; exp_c[u] = '0; exp_m[u] = '0;
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_batch(0, da, dt);
        wait_valid(0, "post_rst", 1'b0, tv1);
        after_pulse(0, "post_rst");

        for (int i = 0; i < 5; i++) begin
            start_batch(0, rand_vec(1'b1), rand_vec(i[0]));
            wait_valid(0, "rand", 1'b0, tv1);
            after_pulse(0, "rand");
        end

        ra = rand_vec(1'b1);
        rt = rand_vec(1'b0);
        start_batch(0, rand_vec(1'b1), rand_vec(1'b1));
        wait_valid(0, "b2b_first", 1'b0, tv1);
        start_batch(0, ra, rt);
        wait_valid(0, "b2b_second", 1'b0, tv2);
        check("b2b_gap", (tv2 - tv1) / 10, LAT4 + 1);
        after_pulse(0, "b2b");

        start_batch(1, rand_vec(1'b1), rand_vec(1'b0));
        wait_valid(1, "n1_rand", 1'b0, tv1);
        after_pulse(1, "n1_rand");
        start_batch(1, (N*W)'(32'h0100_0000), (N*W)'(32'h0100_0000));
        wait_valid(1, "n1_one", 1'b0, tv1);
        check("n1_one_delta_const", delta1, 32'h0);
        check("n1_one_cost_const", cost1, 32'h0);
        after_pulse(1, "n1_one");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
